vga_fetch: RTL
==============

# vga_fetch

Memory-read stage directly upstream of the VGA output stage. It turns the display's current pixel coordinates (`clocked_hcount`/`clocked_vcount`) and the `vga_flag` request into ZBT read requests through the memory arbiter. It returns one 36-bit word (two packed 18-bit YCrCb pixels) on `vga_pixel`, with a one-cycle `done_vga` pulse. It also owns double-buffer selection, swapping the displayed frame buffer only at the start of vertical blanking.

## Interface
- `MEM_LAT`, 2: cycles from `mem_ack` to valid `mem_rdata`.
- `BUF0_BASE`, 19'd0: word base address of frame buffer 0.
- `BUF1_BASE`, 19'd153600: word base address of frame buffer 1 (480×320 words after buffer 0).
- `clock` in 1: single system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-low.
- `frame_flag` in 1: one-cycle pulse from the capture side meaning "new frame complete".
- `vga_flag` in 1: fetch request level from the VGA output stage.
- `clocked_hcount` in `LOG_HCOUNT`: display column, updated every 2 vclocks.
- `clocked_vcount` in `LOG_VCOUNT`: display line.
- `mem_req` out 1: read request to the arbiter.
- `mem_addr` out `LOG_ADDR` (19): word address; stable while `mem_req` is high.
- `mem_ack` in 1: one-cycle grant; the request is accepted on this cycle.
- `mem_rdata` in `LOG_MEM` (36): read data, valid exactly `MEM_LAT` cycles after `mem_ack`.
- `vga_pixel` out `LOG_MEM`: last fetched word; [35:18] holds the odd pixel, [17:0] the even pixel.
- `done_vga` out 1: one-cycle pulse in the cycle `vga_pixel` updates.
- `display_buf` out 1: currently displayed buffer (0 or 1).

## Operation
- Word address: `base + vcount*320 + hcount[9:1]`. Base is `BUF0_BASE` or `BUF1_BASE` according to `display_buf`. The multiply is `(vcount<<8)+(vcount<<6)`, computed at 19 bits with no truncation for vcount ≤ 479.
- Active region: hcount < 640 and vcount < 480. Outside it, no fetch is issued and `vga_pixel` holds its value.
- `last_addr` register: a fetch is started only if the computed address differs from `last_addr`. `last_addr` resets to all-ones, so the first fetch always occurs.
- FSM:
  - IDLE: when `vga_flag`=1, the pixel is active and the address is new, latch `mem_addr` and `last_addr`, assert `mem_req`, go to REQ.
  - REQ: hold `mem_req` and `mem_addr` until `mem_ack`. On `mem_ack`, drop `mem_req` next cycle and go to WAIT.
  - WAIT: count `MEM_LAT` cycles, capture `mem_rdata` into `vga_pixel`, pulse `done_vga`, go to IDLE.
- Only one outstanding read at a time. `vga_flag` changes during REQ/WAIT are ignored.
- Buffer swap:
  - `frame_flag` sets `swap_pending`.
  - When `clocked_vcount` first equals 480 with `swap_pending` set, `display_buf` toggles, `swap_pending` clears, and `last_addr` resets to all-ones.
  - If `frame_flag` and the vcount==480 cycle coincide, the swap occurs in that cycle.
  - A second `frame_flag` before the swap has no extra effect.
- Reset mid-fetch: the FSM returns to IDLE, the latency counter clears, and any `mem_rdata` arriving afterwards is ignored.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `vga_pixel`=0, `done_vga`=0, `display_buf`=0, `swap_pending`=0, state=IDLE.
- Request issue: `mem_req` rises the cycle after the IDLE trigger condition is sampled.
- Uncontended (ack in the first REQ cycle): `done_vga` fires `MEM_LAT`+2 cycles after the trigger edge. With `MEM_LAT`=2, that is 4 cycles, matching the VGA stage's capture window.
- Contended: latency grows by one cycle per cycle `mem_ack` is withheld.
- `mem_addr` is registered and never changes while `mem_req`=1.

## Configuration
- `VGA_FETCH_TESTPAT_EN`:
  - Defined: memory is never requested (`mem_req` tied 0). Each trigger instead produces eight vertical YCrCb colour bars selected by hcount[9:7], returned with identical FSM timing (WAIT counts `MEM_LAT` without waiting on `mem_ack`).
  - Undefined: normal memory fetch.

## Structure
- `params.v` holds `LOG_MEM`, `LOG_ADDR`, `LOG_HCOUNT`, `LOG_VCOUNT`, `VGA_HACTIVE`=640, `VGA_VACTIVE`=480, `VGA_WORDS_PER_LINE`=320, and the state encodings.
- One sub-module, `fetch_addr_gen`: a combinational base+vcount*320+hcount[9:1] calculator with an active-region flag, reusable by the capture writer.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then release with `vga_flag`=1, hcount=7, vcount=2. Expect `mem_addr`=643, `mem_req` high one cycle later, and all outputs 0 during reset.
- Read: `mem_ack` in the first REQ cycle, `mem_rdata`=36'h123456789 two cycles later. Expect `vga_pixel`=36'h123456789 and a single `done_vga` pulse 4 cycles after the trigger.
- Contention: withhold `mem_ack` for 5 cycles. Expect `mem_addr` stable, no second request, and `done_vga` at 9 cycles.
- Duplicate and blanking: hcount 6→7 (same word). Expect no new `mem_req`. hcount=700. Expect no request and `vga_pixel` held.
- Swap: `frame_flag` pulse at vcount=100. Expect `display_buf` to toggle only when vcount=480. The next fetch at hcount=7, vcount=2 must give `mem_addr`=154243.
- Reset mid-WAIT: pulse reset one cycle after `mem_ack`. Expect the late `mem_rdata` to be ignored, `vga_pixel`=0, and no `done_vga`.

Source files
------------

// File: rtl/vga_fetch_pkg.sv
// vga_fetch_pkg: shared widths, display geometry, fetch FSM state type and
// the colour-bar helper used by the vga_fetch memory-read stage.
package vga_fetch_pkg;

    localparam int unsigned LOG_MEM    = 36;
    localparam int unsigned LOG_ADDR   = 19;
    localparam int unsigned LOG_HCOUNT = 11;
    localparam int unsigned LOG_VCOUNT = 10;

    localparam int unsigned VGA_HACTIVE        = 640;
    localparam int unsigned VGA_VACTIVE        = 480;
    localparam int unsigned VGA_WORDS_PER_LINE = 320;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

    // Eight vertical bars, each pixel packed as {Y[5:0], Cr[5:0], Cb[5:0]};
    // both pixels of the word carry the same colour.
    function automatic logic [LOG_MEM-1:0] testpat_word(input logic [2:0] bar);
        logic [17:0] px;
        case (bar)
            3'd0:    px = {6'd60, 6'd32, 6'd32}; // white
            3'd1:    px = {6'd52, 6'd34, 6'd8 }; // yellow
            3'd2:    px = {6'd42, 6'd8,  6'd42}; // cyan
            3'd3:    px = {6'd36, 6'd12, 6'd18}; // green
            3'd4:    px = {6'd26, 6'd52, 6'd46}; // magenta
            3'd5:    px = {6'd20, 6'd56, 6'd22}; // red
            3'd6:    px = {6'd10, 6'd30, 6'd56}; // blue
            default: px = {6'd4,  6'd32, 6'd32}; // black
        endcase
        return {px, px};
    endfunction

endpackage

// File: rtl/vga_fetch_if.sv
// vga_fetch_if: read port between the fetch stage and the ZBT memory arbiter.
//   mem_req   : read request (master -> arbiter)
//   mem_addr  : word address, stable while mem_req is high
//   mem_ack   : one-cycle grant (arbiter -> master)
//   mem_rdata : read data, valid MEM_LAT cycles after the grant cycle
interface vga_fetch_if;
    import vga_fetch_pkg::*;

    logic                mem_req;
    logic [LOG_ADDR-1:0] mem_addr;
    logic                mem_ack;
    logic [LOG_MEM-1:0]  mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/vga_fetch_addr_gen.sv
// fetch_addr_gen: combinational frame-buffer word address calculator.
//   base   : word base address of the selected frame buffer
//   hcount : display column (two pixels per word, so hcount[9:1] is the word)
//   vcount : display line
//   addr   : base + vcount*320 + hcount[9:1]
//   active : high inside the 640x480 visible region
module fetch_addr_gen
    import vga_fetch_pkg::*;
(
    input  logic [LOG_ADDR-1:0]   base,
    input  logic [LOG_HCOUNT-1:0] hcount,
    input  logic [LOG_VCOUNT-1:0] vcount,
    output logic [LOG_ADDR-1:0]   addr,
    output logic                  active
);

    logic [LOG_ADDR-1:0] v_ext;
    logic [LOG_ADDR-1:0] h_word;
    logic [LOG_ADDR-1:0] line_off;

    always_comb begin
        v_ext    = LOG_ADDR'(vcount);
        h_word   = LOG_ADDR'(hcount[9:1]);
        // 320 = 256 + 64; 479*320 fits comfortably in 19 bits
        line_off = (v_ext << 8) + (v_ext << 6);
        addr     = base + line_off + h_word;
        active   = (hcount < LOG_HCOUNT'(VGA_HACTIVE)) &&
                   (vcount < LOG_VCOUNT'(VGA_VACTIVE));
    end

endmodule

// File: rtl/vga_fetch.sv
// vga_fetch: memory-read stage feeding the VGA output stage.
// Turns the current display coordinates plus the vga_flag request into one
// ZBT read at a time, returns the 36-bit word (odd pixel [35:18], even pixel
// [17:0]) on vga_pixel with a one-cycle done_vga pulse, and owns the
// double-buffer selection, swapping only on entry to vertical blanking.
//
// Ports:
//   clock, reset          : system clock, synchronous active-low reset
//   frame_flag            : pulse, capture side finished a frame
//   vga_flag              : fetch request level from the output stage
//   clocked_hcount/vcount : current display coordinates
//   mem                   : arbiter read port (vga_fetch_if.master)
//   vga_pixel             : last fetched word
//   done_vga              : pulse in the cycle vga_pixel updates
//   display_buf           : buffer currently displayed
//
// Build option: VGA_FETCH_TESTPAT_EN replaces memory reads with eight
// vertical colour bars (hcount[9:7]) at identical FSM timing; mem_req is 0.
module vga_fetch
    import vga_fetch_pkg::*;
#(
    parameter int unsigned         MEM_LAT   = 2,
    parameter logic [LOG_ADDR-1:0] BUF0_BASE = 19'd0,
    parameter logic [LOG_ADDR-1:0] BUF1_BASE = 19'd153600
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_flag,
    input  logic                  vga_flag,
    input  logic [LOG_HCOUNT-1:0] clocked_hcount,
    input  logic [LOG_VCOUNT-1:0] clocked_vcount,
    vga_fetch_if.master           mem,
    output logic [LOG_MEM-1:0]    vga_pixel,
    output logic                  done_vga,
    output logic                  display_buf
);

    localparam logic [7:0] LAT_LAST = 8'(MEM_LAT - 1);

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic [7:0]          lat_cnt;
    logic [LOG_ADDR-1:0] last_addr;
    logic [LOG_ADDR-1:0] addr_q;
    logic [LOG_ADDR-1:0] calc_addr;
    logic [LOG_ADDR-1:0] buf_base;
    logic                pix_active;
    logic                trigger;
    logic                granted;
    logic                lat_done;
    logic                issue;
    logic                capture;
    logic                swap_pending;
    logic                was_blank;
    logic                blank_start;
    logic                swap_now;
    logic [LOG_MEM-1:0]  fetched;

    assign buf_base = display_buf ? BUF1_BASE : BUF0_BASE;

    fetch_addr_gen u_addr_gen (
        .base   (buf_base),
        .hcount (clocked_hcount),
        .vcount (clocked_vcount),
        .addr   (calc_addr),
        .active (pix_active)
    );

    assign trigger  = vga_flag && pix_active && (calc_addr != last_addr);
    assign lat_done = (lat_cnt == LAT_LAST);

    // Swap only on the first cycle of line 480, so a flag arriving later in
    // that line waits for the next frame's blanking.
    assign blank_start = (clocked_vcount == LOG_VCOUNT'(VGA_VACTIVE)) && !was_blank;
    assign swap_now    = blank_start && (swap_pending || frame_flag);

    assign mem.mem_addr = addr_q;

`ifdef VGA_FETCH_TESTPAT_EN
    logic [2:0] bar_sel;

    // REQ lasts exactly one cycle, standing in for an immediate grant
    assign granted     = 1'b1;
    assign mem.mem_req = 1'b0;
    assign fetched     = testpat_word(bar_sel);

    always_ff @(posedge clock) begin
        if (!reset) begin
            bar_sel <= '0;
        end else if (issue) begin
            bar_sel <= clocked_hcount[9:7];
        end
    end
`else
    logic req_q;

    assign granted     = mem.mem_ack;
    assign mem.mem_req = req_q;
    assign fetched     = mem.mem_rdata;

    always_ff @(posedge clock) begin
        if (!reset) begin
            req_q <= 1'b0;
        end else if (issue) begin
            req_q <= 1'b1;
        end else if (state == ST_REQ && granted) begin
            req_q <= 1'b0;
        end
    end
`endif

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (trigger)  state_next = ST_REQ;
            ST_REQ:  if (granted)  state_next = ST_WAIT;
            ST_WAIT: if (lat_done) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output strobes
    always_comb begin
        issue   = 1'b0;
        capture = 1'b0;
        case (state)
            ST_IDLE: issue   = trigger;
            ST_WAIT: capture = lat_done;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clock) begin
        if (!reset) begin
            lat_cnt      <= '0;
            addr_q       <= '0;
            last_addr    <= '1;
            vga_pixel    <= '0;
            done_vga     <= 1'b0;
            display_buf  <= 1'b0;
            swap_pending <= 1'b0;
            was_blank    <= 1'b0;
        end else begin
            if (state == ST_WAIT && !lat_done) begin
                lat_cnt <= lat_cnt + 8'd1;
            end else begin
                lat_cnt <= '0;
            end

            if (issue) begin
                addr_q <= calc_addr;
            end

            done_vga <= capture;
            if (capture) begin
                vga_pixel <= fetched;
            end

            was_blank <= (clocked_vcount == LOG_VCOUNT'(VGA_VACTIVE));

            // Blanking is outside the active region, so swap and issue never
            // coincide; the swap still wins to force a fresh first fetch.
            if (swap_now) begin
                display_buf  <= ~display_buf;
                swap_pending <= 1'b0;
                last_addr    <= '1;
            end else begin
                swap_pending <= swap_pending | frame_flag;
                if (issue) begin
                    last_addr <= calc_addr;
                end
            end
        end
    end

endmodule
